hilo_div_unit: RTL and testbench
================================

Name: hilo_div_unit

Overview:
- Multi-cycle 32-bit divider in the execute stage of the 5-stage MIPS pipeline.
- Implements DIV and DIVU and is the producing end of the HILO write channel. That channel is carried through execute to the memory stage as enabler/HI/LO.
- Runs a radix-2 restoring division over 32 cycles, stalling the pipeline until done.
- Delivers quotient on LO and remainder on HI with a HILO write-enable.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- start  input  1  divide request from ID/EX; held high while stalled
- signed_op  input  1  1 = DIV, 0 = DIVU; sampled with start in IDLE
- dividend  input  WIDTH  rs operand; sampled in IDLE
- divisor  input  WIDTH  rt operand; sampled in IDLE
- annul  input  1  flush/exception cancel of the in-flight divide
- stall_req  output  1  pipeline stall request
- hilo_we  output  1  HILO write enable toward the execute-to-memory HILO channel
- hi_out  output  WIDTH  remainder
- lo_out  output  WIDTH  quotient

Behaviour:
- Reset: rst is synchronous, active-high. On rst the FSM goes to IDLE, the counter is 0, the internal registers are 0, and stall_req=0, hilo_we=0, hi_out=0, lo_out=0. rst overrides all other inputs, including in mid-operation.
- States: IDLE, ZERO, BUSY, DONE.
- IDLE:
  - start=0: remain in IDLE.
  - start=1, annul=0, divisor==0: go to ZERO.
  - start=1, annul=0, divisor!=0: go to BUSY. Latch the operands:
    - signed_op=1: latch magnitudes (two's-complement negate if the MSB is set), plus q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
    - signed_op=0: latch the raw operands, with q_neg = r_neg = 0.
  - Clear the partial remainder and the counter.
- BUSY, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem_shifted - divisor_mag, computed at WIDTH+1 bits.
  - Trial non-negative: rem = trial and quo LSB = 1. Otherwise restore, and quo LSB = 0.
  - Counter increments. When the counter reaches WIDTH-1, the next state is DONE.
  - Total: exactly WIDTH (32) BUSY cycles.
- DONE:
  - Apply sign fixup: lo_out = q_neg ? -quo : quo and hi_out = r_neg ? -rem : rem.
  - Outputs are registered on entry and held stable for the whole of DONE.
  - Remain in DONE while start=1. Return to IDLE on the first cycle start=0.
- ZERO: lo_out = 0, hi_out = 0. Then proceed exactly as in DONE. The MIPS result is architecturally undefined; this value is the team's fixed choice.
- stall_req: 1 in IDLE when start=1 and annul=0 (combinational), and 1 throughout BUSY. It is 0 in DONE, ZERO and IDLE otherwise.
- hilo_we: 1 only in DONE or ZERO, and 0 elsewhere.
- Latency: start asserted in IDLE at cycle 0 → BUSY for cycles 1..32 → DONE at cycle 33 with hilo_we=1 and stall_req=0.
- annul:
  - In BUSY, annul forces IDLE next cycle; no hilo_we pulse and no output update.
  - In IDLE, annul suppresses acceptance of start.
  - In DONE or ZERO, annul forces IDLE and drops hilo_we the next cycle.
- Back-to-back: a new divide is accepted only from IDLE. After DONE, start must drop for at least one cycle.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000 (wraps), remainder 0. No trap.
- Operands changing while in BUSY or DONE are ignored, because the internal copies are latched.
- hi_out and lo_out keep their last values in IDLE. Consumers qualify them with hilo_we.

Decomposition:
- Shared package (mips_defs):
  - the state encoding enum
  - WIDTH
  - the ZERO-result constant, 0
- One natural sub-module: div_iter_step. It is purely combinational and computes the shift, trial subtract and restore for one iteration, taking {rem, quo, divisor_mag} and producing {rem_next, quo_next}.
- The FSM, counter, sign handling and output registers remain in hilo_div_unit.

Test Plan:
- DIVU 100/7: start=1, signed_op=0 → stall_req=1 for cycles 0..32. At cycle 33, hilo_we=1, lo_out=14, hi_out=2 and stall_req=0.
- DIV -7/2 (0xFFFFFFF9 / 0x2): at cycle 33, lo_out=0xFFFFFFFD and hi_out=0xFFFFFFFF. Also check 7/-2 gives lo=0xFFFFFFFD and hi=1.
- Divide by zero, 5/0: the cycle after start, state is ZERO with hilo_we=1, lo_out=0, hi_out=0 and stall_req=0. No BUSY cycles occur.
- Annul at cycle 10 of BUSY (DIVU 0xFFFFFFFF/3): IDLE at cycle 11, with stall_req=0 and hilo_we never asserted. A fresh 9/3 then yields lo=3, hi=0 at the expected cycle.
- Reset mid-operation (rst=1 at BUSY cycle 20): the next cycle shows all outputs 0 and IDLE. Signed 0x80000000/0xFFFFFFFF afterwards yields lo=0x80000000, hi=0.
- DONE hold/exit: keep start=1 for 3 cycles after DONE → hilo_we=1 with stable outputs for all 3 cycles. Dropping start returns the FSM to IDLE the next cycle with hilo_we=0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// mips_defs: shared types and constants for the execute-stage HILO producers
package mips_defs;
  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] ZERO_RESULT = '0;
  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} div_state_e;
endpackage

// File: rtl/hilo_div_unit_step.sv
// div_iter_step: one radix-2 restoring division iteration (shift, trial subtract, restore)
module div_iter_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dmag_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0] shifted, trial;
  logic       fits;
  // rem < dmag on entry, so the shifted value is < 2*dmag and W+1 bits hold the trial exactly
  assign shifted = {rem_i, quo_i[W-1]};
  assign trial   = shifted - {1'b0, dmag_i};
  assign fits    = !trial[W];
  assign rem_o   = fits ? trial[W-1:0] : shifted[W-1:0];
  assign quo_o   = {quo_i[W-2:0], fits};
endmodule

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: multi-cycle DIV/DIVU, quotient on LO and remainder on HI,
// stalling the pipeline for WIDTH iterations and then raising hilo_we.
module hilo_div_unit #(
  parameter int WIDTH = mips_defs::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stall_req,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  import mips_defs::*;
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, rem_n, quo_n;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, accept;
  div_iter_step #(.W(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dmag_i(dmag_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );
  assign accept    = state_q == IDLE && start && !annul;
  assign stall_req = accept || state_q == BUSY;
  assign hilo_we   = state_q == DONE || state_q == ZERO;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (accept) begin
        if (divisor == '0) begin
          state_d = ZERO;
          hi_d    = ZERO_RESULT;
          lo_d    = ZERO_RESULT;
        end else begin
          state_d = BUSY;
          quo_d   = signed_op && dividend[WIDTH-1] ? -dividend : dividend;
          dmag_d  = signed_op && divisor[WIDTH-1] ? -divisor : divisor;
          q_neg_d = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d = signed_op && dividend[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: if (annul) state_d = IDLE;
      else begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          lo_d    = q_neg_q ? -quo_n : quo_n;
          hi_d    = r_neg_q ? -rem_n : rem_n;
        end
      end
      default: if (annul || !start) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: directed divides with a result scoreboard checked by a negedge monitor
module tb_hilo_div_unit;
  localparam int W = 32;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, signed_op = 1'b0, annul = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         stall_req, hilo_we;
  logic [W-1:0] hi_out, lo_out;
  int           n_cmp = 0, n_bad = 0, cyc = 0;
  logic         we_d = 1'b0;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           at;
  } exp_t;
  exp_t sb[$];
  exp_t cur = '{'0, '0, 0};

  hilo_div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_op(signed_op),
    .dividend (dividend),
    .divisor  (divisor),
    .annul    (annul),
    .stall_req(stall_req),
    .hilo_we  (hilo_we),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a new result is popped on each rising hilo_we and held for every DONE/ZERO cycle
  always @(negedge clk) begin
    if (hilo_we && !we_d) begin
      if (sb.size() == 0) chk("unexpected_hilo_we", 64'(hilo_we), 64'd0);
      else begin
        cur = sb.pop_front();
        chk("latency", 64'(cyc), 64'(cur.at));
      end
    end
    if (hilo_we) begin
      chk("lo_out", 64'(lo_out), 64'(cur.lo));
      chk("hi_out", 64'(hi_out), 64'(cur.hi));
      chk("stall_in_done", 64'(stall_req), 64'd0);
    end
    we_d <= hilo_we;
  end

  task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] hi, input logic [W-1:0] lo, input int hold);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    e.hi = hi; e.lo = lo; e.at = cyc + (b == '0 ? 1 : 33);
    sb.push_back(e);
    @(negedge clk);
    while (!hilo_we && n < 40) begin
      chk("stall_busy", 64'(stall_req), 64'd1);
      n++;
      @(negedge clk);
    end
    if (!hilo_we) begin
      chk("timeout", 64'd0, 64'd1);
      sb.delete();
    end
    dividend = 32'hDEADBEEF; divisor = 32'h1;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("we_drop", 64'(hilo_we), 64'd0);
    chk("stall_idle", 64'(stall_req), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_we", 64'(hilo_we), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0);
    run_div(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 0);
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 0);
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
    // annul during BUSY cycle 10: no result must ever appear
    @(posedge clk); #1;
    start = 1'b1; signed_op = 1'b0; dividend = 32'hFFFFFFFF; divisor = 32'd3;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("annul_busy_stall", 64'(stall_req), 64'd1);
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_idle_stall", 64'(stall_req), 64'd0);
    chk("annul_idle_we", 64'(hilo_we), 64'd0);
    repeat (40) @(negedge clk);
    run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0);
    // synchronous reset at BUSY cycle 20
    @(posedge clk); #1;
    start = 1'b1; signed_op = 1'b0; dividend = 32'h12345678; divisor = 32'h11;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_hi", 64'(hi_out), 64'd0);
    chk("mid_rst_lo", 64'(lo_out), 64'd0);
    chk("mid_rst_stall", 64'(stall_req), 64'd0);
    chk("mid_rst_we", 64'(hilo_we), 64'd0);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
